// File: rtl/dmem_responder.sv
// Data-memory slave for the single-cycle core: word RAM with RV32I
// load/store formatting plus a small tohost / counter MMIO window.
module dmem_responder #(
  parameter int               WIDTH     = 32,
  parameter int               DADDR     = 10,
  parameter logic [DADDR-1:0] MMIO_BASE = 10'h3F0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DADDR-1:0] dmem_addr,
  input  logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_wr_en,
  input  logic             dmem_rd_en,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] dmem_rdata,
  output logic             halt,
  output logic [WIDTH-1:0] exit_code,
  output logic             err,
  output logic [DADDR-1:0] err_addr
);

  localparam int DEPTH = 1 << (DADDR - 2);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             halt_q, halt_d;
  logic [WIDTH-1:0] exit_q, exit_d;
  logic             err_q, err_d;
  logic [DADDR-1:0] err_addr_q, err_addr_d;
  logic [WIDTH-1:0] cyc_q, cyc_d;
  logic [WIDTH-1:0] st_cnt_q, st_cnt_d;

  logic [DADDR-3:0] widx;
  logic [DADDR-3:0] off_w;
  logic             is_mmio;
  logic [WIDTH-1:0] mmio_word;
  logic [WIDTH-1:0] rd_word;
  logic [7:0]       lb;
  logic [15:0]      lh;
  logic [WIDTH-1:0] fmt;
  logic             mis;
  logic             ld_bad;
  logic             st_bad;
  logic             bad;
  logic             do_st;
  logic             ram_we;
  logic             tohost_we;
  logic [3:0]       ram_be;
  logic [WIDTH-1:0] ram_wd;

  // Address decode, legality checks and combinational load path
  always_comb begin
    widx    = dmem_addr[DADDR-1:2];
    off_w   = widx - MMIO_BASE[DADDR-1:2];
    is_mmio = (dmem_addr >= MMIO_BASE);

    mmio_word = '0;
    if (off_w[DADDR-3:2] == '0) begin
      unique case (off_w[1:0])
        2'd0:    mmio_word = exit_q;
        2'd1:    mmio_word = cyc_q;
        2'd2:    mmio_word = st_cnt_q;
        default: mmio_word = '0;
      endcase
    end
    rd_word = is_mmio ? mmio_word : mem[widx];

    mis = ((funct3[1:0] == 2'b01) && dmem_addr[0]) ||
          ((funct3[1:0] == 2'b10) && (dmem_addr[1:0] != 2'b00));
    ld_bad = (funct3 == 3'b011) || (funct3 == 3'b110) ||
             (funct3 == 3'b111) || mis;
    // MMIO only accepts full-word stores; sub-word ones are errors
    st_bad = funct3[2] || (funct3[1:0] == 2'b11) || mis ||
             (is_mmio && (funct3 != 3'b010));
    bad = dmem_wr_en ? st_bad : (dmem_rd_en && ld_bad);

    lb = rd_word[{dmem_addr[1:0], 3'b000} +: 8];
    lh = dmem_addr[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (funct3)
      3'b000:  fmt = {{(WIDTH-8){lb[7]}}, lb};
      3'b100:  fmt = {{(WIDTH-8){1'b0}}, lb};
      3'b001:  fmt = {{(WIDTH-16){lh[15]}}, lh};
      3'b101:  fmt = {{(WIDTH-16){1'b0}}, lh};
      3'b010:  fmt = rd_word;
      default: fmt = '0;
    endcase
    dmem_rdata = (dmem_rd_en && !bad) ? fmt : '0;
  end

  // Store qualification and byte-lane steering
  always_comb begin
    do_st     = dmem_wr_en && !bad && !halt_q && !reset;
    ram_we    = do_st && !is_mmio;
    tohost_we = do_st && is_mmio && (off_w == '0);
    ram_be    = 4'b0000;
    ram_wd    = dmem_wdata;
    unique case (funct3[1:0])
      2'b00: begin
        ram_be = 4'b0001 << dmem_addr[1:0];
        ram_wd = {4{dmem_wdata[7:0]}};
      end
      2'b01: begin
        ram_be = dmem_addr[1] ? 4'b1100 : 4'b0011;
        ram_wd = {2{dmem_wdata[15:0]}};
      end
      2'b10:   ram_be = 4'b1111;
      default: ram_be = 4'b0000;
    endcase
    if (!ram_we) ram_be = 4'b0000;
  end

  // Next-state for halt, exit code, error capture and counters
  always_comb begin
    halt_d     = halt_q;
    exit_d     = exit_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    cyc_d      = cyc_q;
    st_cnt_d   = st_cnt_q;
    if (tohost_we) begin
      halt_d = 1'b1;
      exit_d = dmem_wdata;
    end
    if (bad) begin
      err_d = 1'b1;
      if (!err_q) err_addr_d = dmem_addr;
    end
    if (!halt_q) cyc_d = cyc_q + WIDTH'(1);
    if (ram_we) st_cnt_d = st_cnt_q + WIDTH'(1);
  end

  // Control registers; synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      halt_q     <= 1'b0;
      exit_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      cyc_q      <= '0;
      st_cnt_q   <= '0;
    end else begin
      halt_q     <= halt_d;
      exit_q     <= exit_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      cyc_q      <= cyc_d;
      st_cnt_q   <= st_cnt_d;
    end
  end

  // RAM lane writes; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_be[i]) mem[widx][8*i +: 8] <= ram_wd[8*i +: 8];
    end
  end

  assign halt      = halt_q;
  assign exit_code = exit_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected load
// results, a negedge monitor pops and compares while rd_en is high.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_wr_en = 1'b0;
  logic        dmem_rd_en = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] dmem_rdata;
  logic        halt;
  logic [31:0] exit_code;
  logic        err;
  logic [9:0]  err_addr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    bit          chk;
    logic        h;
    logic        e;
    logic [9:0]  ea;
    logic [31:0] ex;
  } exp_t;

  exp_t sb[$];

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;

  dmem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wr_en (dmem_wr_en),
    .dmem_rd_en (dmem_rd_en),
    .funct3     (funct3),
    .dmem_rdata (dmem_rdata),
    .halt       (halt),
    .exit_code  (exit_code),
    .err        (err),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  task automatic op(input logic r, input logic [9:0] a,
                    input logic [31:0] wd, input logic wr,
                    input logic rd, input logic [2:0] f3);
    @(posedge clk);
    #1;
    reset      = r;
    dmem_addr  = a;
    dmem_wdata = wd;
    dmem_wr_en = wr;
    dmem_rd_en = rd;
    funct3     = f3;
  endtask

  task automatic idle();
    op(1'b0, 10'h000, 32'h0, 1'b0, 1'b0, LW);
  endtask

  task automatic st(input logic [9:0] a, input logic [31:0] wd,
                    input logic [2:0] f3);
    op(1'b0, a, wd, 1'b1, 1'b0, f3);
  endtask

  task automatic ld(input string nm, input logic [9:0] a,
                    input logic [2:0] f3, input logic [31:0] x);
    exp_t e;
    op(1'b0, a, 32'h0, 1'b0, 1'b1, f3);
    e = '{nm, x, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0};
    sb.push_back(e);
  endtask

  task automatic ldst(input string nm, input logic [9:0] a,
                      input logic [2:0] f3, input logic [31:0] x,
                      input logic h, input logic er,
                      input logic [9:0] ea, input logic [31:0] ex);
    exp_t e;
    op(1'b0, a, 32'h0, 1'b0, 1'b1, f3);
    e = '{nm, x, 1'b1, h, er, ea, ex};
    sb.push_back(e);
  endtask

  // Monitor: one scoreboard entry per cycle with a load presented
  always @(negedge clk) begin
    if (dmem_rd_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got rdata %h, want none",
                 dmem_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (dmem_rdata !== e.rd) begin
          errors++;
          $display("FAIL %s rdata: got %h want %h", e.nm,
                   dmem_rdata, e.rd);
        end
        if (e.chk) begin
          checks += 4;
          if (halt !== e.h) begin
            errors++;
            $display("FAIL %s halt: got %b want %b", e.nm, halt, e.h);
          end
          if (err !== e.e) begin
            errors++;
            $display("FAIL %s err: got %b want %b", e.nm, err, e.e);
          end
          if (err_addr !== e.ea) begin
            errors++;
            $display("FAIL %s err_addr: got %h want %h", e.nm,
                     err_addr, e.ea);
          end
          if (exit_code !== e.ex) begin
            errors++;
            $display("FAIL %s exit_code: got %h want %h", e.nm,
                     exit_code, e.ex);
          end
        end
      end
    end
  end

  initial begin
    // reset, then cycle counter reads 0,1 and 5 after 5 cycles
    op(1'b1, 10'h0, 32'h0, 1'b0, 1'b0, LW);
    op(1'b1, 10'h0, 32'h0, 1'b0, 1'b0, LW);
    ldst("rst_state", 10'h3F4, LW, 32'd0, 1'b0, 1'b0, 10'h0, 32'h0);
    ld("cyc_1", 10'h3F4, LW, 32'd1);
    idle(); idle(); idle();
    ld("cyc_5", 10'h3F4, LW, 32'd5);

    // load formatting
    st(10'h010, 32'h8765_4321, LW);
    ld("lb_13", 10'h013, LB, 32'hFFFF_FF87);
    ld("lbu_13", 10'h013, LBU, 32'h0000_0087);
    ld("lb_10", 10'h010, LB, 32'h0000_0021);
    ld("lh_12", 10'h012, LH, 32'hFFFF_8765);
    ld("lhu_12", 10'h012, LHU, 32'h0000_8765);
    ld("lhu_10", 10'h010, LHU, 32'h0000_4321);
    ld("lw_10", 10'h010, LW, 32'h8765_4321);

    // byte-lane stores
    st(10'h020, 32'hFFFF_FFFF, LW);
    st(10'h021, 32'h1234_565A, LB);
    st(10'h022, 32'hABCD_1234, LH);
    ld("lanes", 10'h020, LW, 32'h1234_5AFF);
    ld("stcnt_4", 10'h3F8, LW, 32'd4);

    // rd+wr together: old data now, new data next cycle
    op(1'b0, 10'h020, 32'h1111_1111, 1'b1, 1'b1, LW);
    sb.push_back('{"rdwr_old", 32'h1234_5AFF, 1'b0, 1'b0, 1'b0,
                   10'h0, 32'h0});
    ld("rdwr_new", 10'h020, LW, 32'h1111_1111);

    // misaligned store, later misaligned / illegal loads
    st(10'h030, 32'hCAFE_F00D, LW);
    st(10'h040, 32'h0BAD_C0DE, LW);
    st(10'h031, 32'h0000_BEEF, LH);
    ldst("mis_sh", 10'h030, LW, 32'hCAFE_F00D, 1'b0, 1'b1,
         10'h031, 32'h0);
    ldst("mis_lw", 10'h036, LW, 32'h0, 1'b0, 1'b1, 10'h031, 32'h0);
    ld("ill_ld", 10'h030, 3'b011, 32'h0);
    ld("stcnt_7", 10'h3F8, LW, 32'd7);

    // store during reset is dropped, RAM kept, registers cleared
    op(1'b1, 10'h040, 32'hDEAD_BEEF, 1'b1, 1'b0, LW);
    ldst("rst_st", 10'h040, LW, 32'h0BAD_C0DE, 1'b0, 1'b0,
         10'h0, 32'h0);
    ld("stcnt_rst", 10'h3F8, LW, 32'd0);

    // cycle counter wrap
    @(posedge clk);
    #1;
    dmem_rd_en = 1'b0;
    dmem_wr_en = 1'b0;
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    ld("cyc_wrap", 10'h3F4, LW, 32'd0);
    ld("cyc_wrap1", 10'h3F4, LW, 32'd1);

    // tohost halt, frozen counter, ignored stores
    st(10'h3F0, 32'h0000_002A, LW);
    ldst("halt", 10'h3F0, LW, 32'h0000_002A, 1'b1, 1'b0,
         10'h0, 32'h0000_002A);
    ld("cyc_frz", 10'h3F4, LW, 32'd3);
    st(10'h040, 32'h5555_5555, LW);
    st(10'h3F0, 32'h0000_0099, LW);
    ld("halt_ram", 10'h040, LW, 32'h0BAD_C0DE);
    ldst("halt_exit", 10'h3F4, LW, 32'd3, 1'b1, 1'b0,
         10'h0, 32'h0000_002A);
    ld("halt_stcnt", 10'h3F8, LW, 32'd0);

    // reset clears halt, RAM retained
    op(1'b1, 10'h0, 32'h0, 1'b0, 1'b0, LW);
    ldst("unhalt", 10'h040, LW, 32'h0BAD_C0DE, 1'b0, 1'b0,
         10'h0, 32'h0);
    ld("tohost_0", 10'h3F0, LW, 32'h0);

    // MMIO: SW to RO offset ignored, SB to tohost is an error
    st(10'h3F8, 32'h0000_1234, LW);
    ldst("ro_sw", 10'h3F8, LW, 32'd0, 1'b0, 1'b0, 10'h0, 32'h0);
    ld("rsvd", 10'h3FC, LW, 32'h0);
    st(10'h3F0, 32'h0000_0077, LB);
    ldst("sb_mmio", 10'h3F0, LW, 32'h0, 1'b0, 1'b1,
         10'h3F0, 32'h0);

    idle();
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core: the slave end of the core's `dmem_addr` / `dmem_wdata` / `dmem_rdata` interface.
- Provides word-organised RAM with RV32I byte/halfword/word load formatting (`funct3`) and byte-lane stores.
- Provides a small memory-mapped I/O window: `tohost` halt register, cycle counter, store counter.
- Flags misaligned and illegal accesses.
- Reads are combinational so the core completes a load in one cycle; writes commit on the clock edge.

## Interface
Parameters:
- `WIDTH`, 32, data width; only 32 is supported.
- `DADDR`, 10, byte-address width; RAM depth = 2^(DADDR-2) words.
- `MMIO_BASE`, 10'h3F0, byte address of the first MMIO word; the region is 16 bytes, word-aligned.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `dmem_addr`  in  DADDR  byte address from core ALU.
- `dmem_wdata`  in  WIDTH  store data (rs2), right-aligned.
- `dmem_wr_en`  in  1  store this cycle.
- `dmem_rd_en`  in  1  load this cycle; used for error checking only.
- `funct3`  in  3  access size/sign from the instruction.
- `dmem_rdata`  out  WIDTH  formatted load data, combinational.
- `halt`  out  1  set by any legal write to `tohost`; sticky.
- `exit_code`  out  WIDTH  value written to `tohost`.
- `err`  out  1  sticky misaligned/illegal access flag.
- `err_addr`  out  DADDR  address of the first erroneous access.

## Operation
- Address decode:
  - `dmem_addr` < `MMIO_BASE` selects RAM word `dmem_addr[DADDR-1:2]`.
  - Otherwise MMIO, by offset:
    - +0: `tohost`, R/W.
    - +4: `cycle_count`, RO.
    - +8: `store_count`, RO.
    - +C: reserved; reads 0, writes ignored.
  - RAM words shadowed by MMIO are unreachable.
- Loads: the selected 32-bit word is formatted by `funct3`.
  - 000 LB: byte at `addr[1:0]`, sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH / 101 LHU: halfword at `addr[1]`, sign-extended (LH) or zero-extended (LHU).
  - 010 LW: full word.
  - 011, 110, 111: illegal.
- Stores, RAM only:
  - 000 SB writes byte lane `addr[1:0]` with `wdata[7:0]`.
  - 001 SH writes lanes {`addr[1]`*2, +1} with `wdata[15:0]`.
  - 010 SW writes all four lanes.
  - Other `funct3` values are illegal.
  - Untouched lanes keep their value.
- MMIO stores: only SW to offset +0 is legal. It latches `exit_code <= wdata` and sets `halt`. SB/SH to MMIO are illegal; SW to +4/+8/+C is ignored without error.
- Misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
- Error handling, for misaligned or illegal access with `rd_en` or `wr_en` high:
  - Store is suppressed.
  - `dmem_rdata` = 0.
  - `err` set.
  - `err_addr` captured only if `err` was clear.
- `dmem_rdata` = 0 whenever `dmem_rd_en` = 0.
- `cycle_count`:
  - 32-bit; +1 every cycle with `reset`=0 and `halt`=0.
  - Wraps FFFF_FFFF→0.
- `store_count`:
  - 32-bit; +1 per committed legal RAM store.
  - Wraps.
- After `halt`:
  - All stores are ignored (RAM, `tohost`, counters frozen).
  - Loads still work.
  - `halt` clears only on reset.
- `rd_en` and `wr_en` both high: treat as store; `dmem_rdata` shows pre-store data.

## Timing
- Load: combinational, same cycle as address; zero latency.
- Store: commits on the rising edge where `wr_en`=1. A load of the same address in the next cycle returns new data; a same-cycle load returns old data.
- Reset values, the cycle after `reset` high:
  - `halt`=0, `exit_code`=0, `err`=0, `err_addr`=0.
  - `cycle_count`=0, `store_count`=0.
  - RAM contents are not cleared; they are preserved across reset.
- Stores presented while `reset`=1 are suppressed.
- `cycle_count` reads 0 in the first cycle after reset deasserts and 1 in the next.
- `halt`/`exit_code` are visible the cycle after the `tohost` store edge. The counter does not increment on that edge's successor.
- Reset asserted mid-run (halted or not) returns all registers to reset values on that edge.

## Test plan
- SW 0x8765_4321 to 0x010, then LB/LBU/LH/LHU/LW at 0x010–0x013 → LB@0x013 = FFFF_FF87, LBU@0x013 = 0000_0087, LH@0x012 = FFFF_8765, LHU@0x010 = 0000_4321, LW = 8765_4321.
- SW 0xFFFF_FFFF to 0x020, then SB 0x5A @0x021 and SH 0x1234 @0x022 → LW 0x020 = 1234_5AFF; `store_count` = 3.
- SH @0x031 with `wdata` 0xBEEF → RAM unchanged; `err`=1, `err_addr`=0x031. A later LW @0x036 keeps `err_addr`=0x031 and returns 0.
- Release reset, idle 5 cycles, LW `MMIO_BASE`+4 → 5. Preload `cycle_count` to FFFF_FFFF via force; one cycle later it reads 0.
- SW 0x2A to `MMIO_BASE` → next cycle `halt`=1, `exit_code`=0x2A. A subsequent SW to 0x040 is ignored and `cycle_count` stays constant. Reset clears `halt` while RAM keeps prior data.
- SW with `reset`=1 → no RAM change; SB to `MMIO_BASE` → `err`=1, `halt` stays 0.
